// File: rtl/sandpile_drop_ctrl.sv
//==============================================================================
// Module  : sandpile_drop_ctrl
// Purpose : Frame-paced drop scheduler (centre / LFSR-random / manual sources)
//           for the sandpile array. Rev 1.0
//==============================================================================
`default_nettype none

module sandpile_drop_ctrl #(
    parameter int          COORD_W = 9,
    parameter int          RATE_W  = 8,
    parameter logic [15:0] SEED_X  = 16'hACE1,
    parameter logic [15:0] SEED_Y  = 16'h1D2B
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_frame_i,
    input  logic               enable_i,
    input  logic               mode_i,
    input  logic [COORD_W-1:0] resolution_i,
    input  logic [RATE_W-1:0]  frames_per_drop_i,
    input  logic               manual_req_i,
    input  logic [COORD_W-1:0] manual_x_i,
    input  logic [COORD_W-1:0] manual_y_i,
    output logic               manual_ack_o,
    output logic               drop_o,
    output logic [COORD_W-1:0] drop_x_o,
    output logic [COORD_W-1:0] drop_y_o,
    output logic [15:0]        drop_count_o,
    output logic               err_o
);

    localparam int PW = 17 + COORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [RATE_W-1:0]  frame_cnt;
    logic               pend_valid;
    logic [COORD_W-1:0] pend_x, pend_y;
    logic [15:0]        lfsr_x, lfsr_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (new_frame_i) state_next = DECIDE;
            DECIDE:  state_next = ISSUE;
            ISSUE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [RATE_W-1:0]  k_eff;
    logic [RATE_W:0]    cnt_inc;
    logic               auto_due, res_ok, in_decide;
    logic               take_manual, take_auto, take_random, manual_ok;
    logic [15:0]        lfsr_x_next, lfsr_y_next;
    logic [PW-1:0]      prod_x, prod_y;

    always_comb begin
        k_eff       = (frames_per_drop_i == '0) ? RATE_W'(1) : frames_per_drop_i;
        cnt_inc     = {1'b0, frame_cnt} + (RATE_W+1)'(1);
        auto_due    = enable_i && (cnt_inc >= {1'b0, k_eff});
        res_ok      = (resolution_i != '0);
        in_decide   = (state == DECIDE);
        take_manual = in_decide && res_ok && pend_valid;
        take_auto   = in_decide && res_ok && !pend_valid && auto_due;
        take_random = take_auto && mode_i;
        // A zero resolution fails both compares, so it rejects every request.
        manual_ok   = manual_req_i && (manual_x_i < resolution_i)
                                   && (manual_y_i < resolution_i);
        lfsr_x_next = {lfsr_x[14:0], lfsr_x[15] ^ lfsr_x[13] ^ lfsr_x[12] ^ lfsr_x[10]};
        lfsr_y_next = {lfsr_y[14:0], lfsr_y[15] ^ lfsr_y[13] ^ lfsr_y[12] ^ lfsr_y[10]};
        // Scaling a 16-bit fraction by N keeps the coordinate strictly below N.
        prod_x      = PW'(lfsr_x_next) * PW'(resolution_i);
        prod_y      = PW'(lfsr_y_next) * PW'(resolution_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_o       <= 1'b0;
            manual_ack_o <= 1'b0;
            drop_x_o     <= '0;
            drop_y_o     <= '0;
            drop_count_o <= '0;
            err_o        <= 1'b0;
            frame_cnt    <= '0;
            pend_valid   <= 1'b0;
            pend_x       <= '0;
            pend_y       <= '0;
            lfsr_x       <= SEED_X;
            lfsr_y       <= SEED_Y;
        end else begin
            drop_o       <= take_manual || take_auto;
            manual_ack_o <= take_manual;

            if (take_manual) begin
                drop_x_o <= pend_x;
                drop_y_o <= pend_y;
            end else if (take_random) begin
                drop_x_o <= prod_x[16 +: COORD_W];
                drop_y_o <= prod_y[16 +: COORD_W];
            end else if (take_auto) begin
                drop_x_o <= resolution_i >> 1;
                drop_y_o <= resolution_i >> 1;
            end

            if (take_random) begin
                lfsr_x <= lfsr_x_next;
                lfsr_y <= lfsr_y_next;
            end

            if ((take_manual || take_auto) && (drop_count_o != 16'hFFFF))
                drop_count_o <= drop_count_o + 16'd1;

            if (manual_req_i && !manual_ok)
                err_o <= 1'b1;

            // A request arriving in DECIDE replaces the slot being consumed.
            if (manual_ok) begin
                pend_valid <= 1'b1;
                pend_x     <= manual_x_i;
                pend_y     <= manual_y_i;
            end else if (take_manual) begin
                pend_valid <= 1'b0;
            end

            // When manual pre-empts a due auto drop the counter holds, so auto fires next frame.
            if (!enable_i)
                frame_cnt <= '0;
            else if (in_decide && res_ok) begin
                if (take_auto)
                    frame_cnt <= '0;
                else if (!auto_due)
                    frame_cnt <= cnt_inc[RATE_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sandpile_drop_ctrl.sv
//==============================================================================
// Module  : tb_sandpile_drop_ctrl
// Purpose : Self-checking bench for sandpile_drop_ctrl against a frame-level model.
//           Rev 1.0
//==============================================================================
`default_nettype none

module tb_sandpile_drop_ctrl;

    logic       clk, rst, new_frame_i, enable_i, mode_i, manual_req_i;
    logic [8:0] resolution_i, manual_x_i, manual_y_i;
    logic [7:0] frames_per_drop_i;
    logic       manual_ack_o, drop_o, err_o;
    logic [8:0] drop_x_o, drop_y_o;
    logic [15:0] drop_count_o;

    int checks = 0;
    int failures = 0;

    // frame-level reference state
    int m_cnt, m_px, m_py, m_lx, m_ly, m_x, m_y, m_count;
    bit m_pend, m_err;
    int c_en, c_mode, c_n, c_k;

    sandpile_drop_ctrl dut (
        .clk(clk), .rst(rst), .new_frame_i(new_frame_i), .enable_i(enable_i),
        .mode_i(mode_i), .resolution_i(resolution_i), .frames_per_drop_i(frames_per_drop_i),
        .manual_req_i(manual_req_i), .manual_x_i(manual_x_i), .manual_y_i(manual_y_i),
        .manual_ack_o(manual_ack_o), .drop_o(drop_o), .drop_x_o(drop_x_o),
        .drop_y_o(drop_y_o), .drop_count_o(drop_count_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lfsr_step(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 32'hFFFF;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_px = 0; m_py = 0;
        m_lx = 32'hACE1; m_ly = 32'h1D2B;
        m_x = 0; m_y = 0; m_count = 0; m_err = 0;
    endtask

    task automatic set_cfg(input int en, input int mode, input int n, input int k);
        c_en = en; c_mode = mode; c_n = n; c_k = k;
        enable_i = en[0]; mode_i = mode[0];
        resolution_i = 9'(n); frames_per_drop_i = 8'(k);
        if (en == 0) m_cnt = 0;
        @(negedge clk);
    endtask

    task automatic manual(input int x, input int y);
        manual_req_i = 1'b1; manual_x_i = 9'(x); manual_y_i = 9'(y);
        @(negedge clk);
        manual_req_i = 1'b0;
        if (x >= c_n || y >= c_n) m_err = 1;
        else begin m_pend = 1; m_px = x; m_py = y; end
    endtask

    task automatic run_frame(input string name);
        bit exp_drop, exp_ack, got_ack;
        int k, pulses, at;
        exp_drop = 0; exp_ack = 0;
        k = (c_k == 0) ? 1 : c_k;
        if (c_en == 0) m_cnt = 0;
        if (c_n != 0) begin
            if (m_pend) begin
                exp_drop = 1; exp_ack = 1; m_x = m_px; m_y = m_py; m_pend = 0;
                if (c_en != 0 && m_cnt + 1 < k) m_cnt++;
            end else if (c_en != 0 && m_cnt + 1 >= k) begin
                exp_drop = 1; m_cnt = 0;
                if (c_mode != 0) begin
                    m_lx = lfsr_step(m_lx); m_ly = lfsr_step(m_ly);
                    m_x = (m_lx * c_n) >> 16; m_y = (m_ly * c_n) >> 16;
                end else begin
                    m_x = c_n / 2; m_y = c_n / 2;
                end
            end else if (c_en != 0) m_cnt++;
        end
        if (exp_drop && m_count < 65535) m_count++;

        new_frame_i = 1'b1;
        @(negedge clk);
        new_frame_i = 1'b0;
        pulses = 0; at = 0; got_ack = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            if (drop_o) begin pulses++; at = i; got_ack = manual_ack_o; end
            else if (manual_ack_o) got_ack = 1;
        end
        checks++;
        if (exp_drop ? (pulses != 1 || at != 2) : (pulses != 0)) begin
            failures++;
            $display("FAIL %s drop: pulses=%0d at=%0d, required pulses=%0d at=2",
                     name, pulses, at, exp_drop);
        end
        checks++;
        if (got_ack !== exp_ack) begin
            failures++;
            $display("FAIL %s ack: got %0b, required %0b", name, got_ack, exp_ack);
        end
        checks++;
        if (drop_x_o !== 9'(m_x) || drop_y_o !== 9'(m_y)) begin
            failures++;
            $display("FAIL %s coords: got (%0d,%0d), required (%0d,%0d)",
                     name, drop_x_o, drop_y_o, m_x, m_y);
        end
        checks++;
        if (drop_count_o !== 16'(m_count) || err_o !== m_err) begin
            failures++;
            $display("FAIL %s count/err: got %0d/%0b, required %0d/%0b",
                     name, drop_count_o, err_o, m_count, m_err);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (drop_o !== 1'b0 || manual_ack_o !== 1'b0 || drop_x_o !== 9'd0 ||
            drop_y_o !== 9'd0 || drop_count_o !== 16'd0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL %s outputs: drop=%0b ack=%0b x=%0d y=%0d cnt=%0d err=%0b, required all 0",
                     name, drop_o, manual_ack_o, drop_x_o, drop_y_o, drop_count_o, err_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; new_frame_i = 0; manual_req_i = 0; manual_x_i = 0; manual_y_i = 0;
        enable_i = 0; mode_i = 0; resolution_i = 0; frames_per_drop_i = 0;
        c_en = 0; c_mode = 0; c_n = 0; c_k = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset_held");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_released");
    endtask

    task automatic test_centre();
        set_cfg(1, 0, 32, 3);
        for (int f = 1; f <= 9; f++) run_frame($sformatf("centre_f%0d", f));
        checks++;
        if (drop_count_o !== 16'd3) begin
            failures++;
            $display("FAIL centre_total: got %0d, required 3", drop_count_o);
        end
        set_cfg(1, 0, 33, 1);
        run_frame("centre_n33");
    endtask

    task automatic test_manual();
        set_cfg(0, 0, 32, 0);
        run_frame("manual_idle");
        manual(5, 7);
        run_frame("manual_5_7");
        run_frame("manual_after");
    endtask

    task automatic test_reject();
        set_cfg(0, 0, 32, 0);
        manual(40, 0);
        run_frame("reject_40_0");
        manual(0, 32);
        run_frame("reject_0_32");
        manual(1, 1);
        run_frame("reject_then_1_1");
    endtask

    task automatic test_collision();
        set_cfg(1, 0, 32, 2);
        run_frame("collide_f1");
        manual(3, 4);
        run_frame("collide_f2_manual");
        run_frame("collide_f3_auto");
        run_frame("collide_f4");
    endtask

    task automatic test_random();
        set_cfg(1, 1, 20, 1);
        for (int f = 0; f < 1000; f++) begin
            run_frame("random_n20");
            checks++;
            if (drop_x_o >= 9'd20 || drop_y_o >= 9'd20) begin
                failures++;
                $display("FAIL random_range: got (%0d,%0d), required < 20", drop_x_o, drop_y_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(1, 1, 20, 1);
        new_frame_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        new_frame_i = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (drop_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_drop: got %0b, required 0", drop_o);
            end
        end
        check_zero("reset_mid_outputs");
        rst = 1'b0;
        @(negedge clk);
        run_frame("reset_mid_seed_reload");
        run_frame("reset_mid_second");
    endtask

    task automatic test_zero_res();
        set_cfg(1, 0, 0, 1);
        run_frame("zero_res_auto");
        manual(0, 0);
        run_frame("zero_res_manual");
        set_cfg(1, 1, 0, 0);
        run_frame("zero_res_random");
    endtask

    task automatic test_random_mix();
        for (int f = 0; f < 400; f++) begin
            if (f % 8 == 0)
                set_cfg(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
                        $urandom_range(1, 500), $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0)
                manual($urandom_range(0, c_n + 3), $urandom_range(0, c_n + 3));
            if ($urandom_range(0, 7) == 0)
                manual($urandom_range(0, c_n - 1), $urandom_range(0, c_n - 1));
            run_frame("random_mix");
        end
    endtask

    initial begin
        test_reset();
        test_centre();
        test_manual();
        test_reject();
        test_collision();
        test_random();
        test_reset_mid();
        test_zero_res();
        test_random_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
